// File: rtl/ysyx_23060221_clint_if.sv
// AXI4 bus bundle between the arbiter's clint_* port group and the CLINT.
// The master drives requests and write data; the slave drives ready, R and B.
interface ysyx_23060221_clint_if;
  logic        clint_awready;
  logic        clint_awvalid;
  logic [31:0] clint_awaddr;
  logic [3:0]  clint_awid;
  logic [7:0]  clint_awlen;
  logic [2:0]  clint_awsize;
  logic [1:0]  clint_awburst;
  logic        clint_wready;
  logic        clint_wvalid;
  logic [31:0] clint_wdata;
  logic [3:0]  clint_wstrb;
  logic        clint_wlast;
  logic        clint_bready;
  logic        clint_bvalid;
  logic [1:0]  clint_bresp;
  logic [3:0]  clint_bid;
  logic        clint_arready;
  logic        clint_arvalid;
  logic [31:0] clint_araddr;
  logic [3:0]  clint_arid;
  logic [7:0]  clint_arlen;
  logic [2:0]  clint_arsize;
  logic [1:0]  clint_arburst;
  logic        clint_rready;
  logic        clint_rvalid;
  logic [1:0]  clint_rresp;
  logic [31:0] clint_rdata;
  logic        clint_rlast;
  logic [3:0]  clint_rid;

  modport slave (
    output clint_awready, clint_wready, clint_bvalid, clint_bresp, clint_bid,
           clint_arready, clint_rvalid, clint_rresp, clint_rdata, clint_rlast, clint_rid,
    input  clint_awvalid, clint_awaddr, clint_awid, clint_awlen, clint_awsize, clint_awburst,
           clint_wvalid, clint_wdata, clint_wstrb, clint_wlast, clint_bready,
           clint_arvalid, clint_araddr, clint_arid, clint_arlen, clint_arsize, clint_arburst,
           clint_rready
  );

  modport master (
    input  clint_awready, clint_wready, clint_bvalid, clint_bresp, clint_bid,
           clint_arready, clint_rvalid, clint_rresp, clint_rdata, clint_rlast, clint_rid,
    output clint_awvalid, clint_awaddr, clint_awid, clint_awlen, clint_awsize, clint_awburst,
           clint_wvalid, clint_wdata, clint_wstrb, clint_wlast, clint_bready,
           clint_arvalid, clint_araddr, clint_arid, clint_arlen, clint_arsize, clint_arburst,
           clint_rready
  );
endinterface

// File: rtl/ysyx_23060221_clint.sv
// Core-local interruptor: free-running 64-bit mtime behind an AXI4 slave.
// Reads return a snapshot taken at the AR handshake so low/high never tear.
// Optional CLINT_MTIMECMP_EN adds mtimecmp at +0x8/+0xC and the mtip output.
module ysyx_23060221_clint #(
  parameter logic [31:0] BASE     = 32'h0200_0000,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  ysyx_23060221_clint_if.slave  bus
`ifdef CLINT_MTIMECMP_EN
  ,output logic                 mtip
`endif
);

  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  r_state_t    r_state, r_next;
  w_state_t    w_state, w_next;

  logic [63:0] mtime, mtime_nxt;
  logic [15:0] presc;
  logic        tick;
  logic [63:0] mtimecmp, mtimecmp_nxt;

  logic [31:0] raddr, roff;
  logic [7:0]  rlen, rbeat;
  logic [3:0]  rid_q;
  logic [63:0] snap_t, snap_c;
  logic        rmap, rlast_i;
  logic [31:0] rword;

  logic [31:0] waddr, woff;
  logic [3:0]  bid_q;
  logic        werr, wmap, wbeat;

  // Byte-lane merge of a bus write into an existing 32-bit word.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (strb[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  assign tick = (presc == 16'(TICK_DIV - 1));

  // Prescaler and timer registers; bus writes land on top of the incremented value.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc    <= '0;
      mtime    <= '0;
      mtimecmp <= '1;
    end else begin
      presc    <= tick ? '0 : presc + 16'd1;
      mtime    <= mtime_nxt;
      mtimecmp <= mtimecmp_nxt;
    end
  end

  // Next timer values: increment first, then overlay written bytes.
  always_comb begin
    mtime_nxt    = mtime + {63'b0, tick};
    mtimecmp_nxt = mtimecmp;
    if (wbeat) begin
      case (woff)
        32'h0: mtime_nxt[31:0]  = merge(mtime_nxt[31:0],  bus.clint_wdata, bus.clint_wstrb);
        32'h4: mtime_nxt[63:32] = merge(mtime_nxt[63:32], bus.clint_wdata, bus.clint_wstrb);
`ifdef CLINT_MTIMECMP_EN
        32'h8: mtimecmp_nxt[31:0]  = merge(mtimecmp[31:0],  bus.clint_wdata, bus.clint_wstrb);
        32'hC: mtimecmp_nxt[63:32] = merge(mtimecmp[63:32], bus.clint_wdata, bus.clint_wstrb);
`endif
        default: ;
      endcase
    end
  end

`ifdef CLINT_MTIMECMP_EN
  // Interrupt pending, registered one cycle behind the compare.
  always_ff @(posedge clk) begin
    if (rst) mtip <= 1'b0;
    else     mtip <= (mtime >= mtimecmp);
  end
`endif

  // ---------------- read channel ----------------

  // Read FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  // Read FSM next state.
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE: if (bus.clint_arvalid) r_next = R_DATA;
      R_DATA: if (bus.clint_rready && rlast_i) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Read burst bookkeeping and the coherent snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      raddr  <= '0;
      rlen   <= '0;
      rbeat  <= '0;
      rid_q  <= '0;
      snap_t <= '0;
      snap_c <= '0;
    end else if (r_state == R_IDLE && bus.clint_arvalid) begin
      raddr  <= bus.clint_araddr;
      rlen   <= bus.clint_arlen;
      rbeat  <= '0;
      rid_q  <= bus.clint_arid;
      snap_t <= mtime;
      snap_c <= mtimecmp;
    end else if (r_state == R_DATA && bus.clint_rready && !rlast_i) begin
      raddr  <= raddr + 32'd4;
      rbeat  <= rbeat + 8'd1;
    end
  end

  assign roff    = raddr - BASE;
  assign rlast_i = (rbeat == rlen);

  // Decode the current read address into a snapshot word.
  always_comb begin
    rmap  = 1'b0;
    rword = '0;
    case (roff)
      32'h0: begin rmap = 1'b1; rword = snap_t[31:0];  end
      32'h4: begin rmap = 1'b1; rword = snap_t[63:32]; end
`ifdef CLINT_MTIMECMP_EN
      32'h8: begin rmap = 1'b1; rword = snap_c[31:0];  end
      32'hC: begin rmap = 1'b1; rword = snap_c[63:32]; end
`endif
      default: ;
    endcase
  end

  // Read FSM outputs; R signals are pure functions of registered state.
  always_comb begin
    bus.clint_arready = (r_state == R_IDLE);
    bus.clint_rvalid  = (r_state == R_DATA);
    bus.clint_rdata   = (r_state == R_DATA && rmap) ? rword : 32'h0;
    bus.clint_rresp   = (r_state == R_DATA && !rmap) ? 2'b11 : 2'b00;
    bus.clint_rlast   = (r_state == R_DATA) && rlast_i;
    bus.clint_rid     = rid_q;
  end

  // ---------------- write channel ----------------

  // Write FSM state register.
  always_ff @(posedge clk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  // Write FSM next state.
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE: if (bus.clint_awvalid) w_next = W_DATA;
      W_DATA: if (bus.clint_wvalid && bus.clint_wlast) w_next = W_RESP;
      W_RESP: if (bus.clint_bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  assign wbeat = (w_state == W_DATA) && bus.clint_wvalid;
  assign woff  = waddr - BASE;

`ifdef CLINT_MTIMECMP_EN
  assign wmap = (woff == 32'h0) || (woff == 32'h4) || (woff == 32'h8) || (woff == 32'hC);
`else
  assign wmap = (woff == 32'h0) || (woff == 32'h4);
`endif

  // Write address/id capture and sticky error across the burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      waddr <= '0;
      bid_q <= '0;
      werr  <= 1'b0;
    end else begin
      if (w_state == W_IDLE && bus.clint_awvalid) begin
        waddr <= bus.clint_awaddr;
        bid_q <= bus.clint_awid;
      end else if (wbeat) begin
        waddr <= waddr + 32'd4;
      end
      if (wbeat && !wmap) werr <= 1'b1;
      else if (w_state == W_RESP && bus.clint_bready) werr <= 1'b0;
    end
  end

  // Write FSM outputs.
  always_comb begin
    bus.clint_awready = (w_state == W_IDLE);
    bus.clint_wready  = (w_state == W_DATA);
    bus.clint_bvalid  = (w_state == W_RESP);
    bus.clint_bresp   = (w_state == W_RESP && werr) ? 2'b11 : 2'b00;
    bus.clint_bid     = bid_q;
  end

  // Only 32-bit beats are supported; flag anything else in simulation.
  always_ff @(posedge clk) begin
    if (!rst && r_state == R_IDLE && bus.clint_arvalid) assert (bus.clint_arsize == 3'b010);
    if (!rst && w_state == W_IDLE && bus.clint_awvalid) assert (bus.clint_awsize == 3'b010);
  end

  // Burst type and write length are implied by INCR and wlast.
  logic unused_ok;
  assign unused_ok = ^{bus.clint_awlen, bus.clint_awburst, bus.clint_arburst, snap_c};

endmodule

// File: tb/tb_ysyx_23060221_clint.sv
// Directed bench for the CLINT: one TICK_DIV=1 instance for the bus tests and
// one TICK_DIV=4 instance for prescaler and mid-burst reset.
module tb_ysyx_23060221_clint;
  localparam logic [31:0] BASE = 32'h0200_0000;

  logic clk = 1'b0;
  logic rst1 = 1'b1;
  logic rst4 = 1'b1;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  ysyx_23060221_clint_if bus1();
  ysyx_23060221_clint_if bus4();
`ifdef CLINT_MTIMECMP_EN
  logic mtip1, mtip4;
`endif

  ysyx_23060221_clint #(.BASE(BASE), .TICK_DIV(1)) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1)
`ifdef CLINT_MTIMECMP_EN
    ,.mtip(mtip1)
`endif
  );

  ysyx_23060221_clint #(.BASE(BASE), .TICK_DIV(4)) dut4 (
    .clk (clk),
    .rst (rst4),
    .bus (bus4)
`ifdef CLINT_MTIMECMP_EN
    ,.mtip(mtip4)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ar1(input logic [31:0] a, input logic [7:0] len, input logic [3:0] id);
    bus1.clint_araddr  = a;
    bus1.clint_arlen   = len;
    bus1.clint_arid    = id;
    bus1.clint_arvalid = 1'b1;
    step();
    bus1.clint_arvalid = 1'b0;
  endtask

  task automatic rbeat1(output logic [31:0] d, output logic [1:0] resp,
                        output logic last, output logic [3:0] id);
    int n;
    n = 0;
    while (!bus1.clint_rvalid && n < 20) begin step(); n++; end
    chk("r_wait", {63'b0, bus1.clint_rvalid}, 64'd1);
    d    = bus1.clint_rdata;
    resp = bus1.clint_rresp;
    last = bus1.clint_rlast;
    id   = bus1.clint_rid;
    bus1.clint_rready = 1'b1;
    step();
    bus1.clint_rready = 1'b0;
  endtask

  task automatic aw1(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
    bus1.clint_awaddr  = a;
    bus1.clint_awid    = id;
    bus1.clint_awlen   = len;
    bus1.clint_awvalid = 1'b1;
    step();
    bus1.clint_awvalid = 1'b0;
  endtask

  task automatic w1(input logic [31:0] d, input logic [3:0] strb, input logic last);
    bus1.clint_wdata  = d;
    bus1.clint_wstrb  = strb;
    bus1.clint_wlast  = last;
    bus1.clint_wvalid = 1'b1;
    step();
    bus1.clint_wvalid = 1'b0;
  endtask

  task automatic b1(output logic [1:0] resp, output logic [3:0] id);
    int n;
    n = 0;
    while (!bus1.clint_bvalid && n < 20) begin step(); n++; end
    chk("b_wait", {63'b0, bus1.clint_bvalid}, 64'd1);
    resp = bus1.clint_bresp;
    id   = bus1.clint_bid;
    bus1.clint_bready = 1'b1;
    step();
    bus1.clint_bready = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
    logic [1:0]  exp_bresp;

    bus1.clint_awvalid = 0; bus1.clint_awaddr = 0; bus1.clint_awid = 0; bus1.clint_awlen = 0;
    bus1.clint_awsize = 3'b010; bus1.clint_awburst = 2'b01;
    bus1.clint_wvalid = 0; bus1.clint_wdata = 0; bus1.clint_wstrb = 0; bus1.clint_wlast = 0;
    bus1.clint_bready = 0; bus1.clint_rready = 0;
    bus1.clint_arvalid = 0; bus1.clint_araddr = 0; bus1.clint_arid = 0; bus1.clint_arlen = 0;
    bus1.clint_arsize = 3'b010; bus1.clint_arburst = 2'b01;
    bus4.clint_awvalid = 0; bus4.clint_awaddr = 0; bus4.clint_awid = 0; bus4.clint_awlen = 0;
    bus4.clint_awsize = 3'b010; bus4.clint_awburst = 2'b01;
    bus4.clint_wvalid = 0; bus4.clint_wdata = 0; bus4.clint_wstrb = 0; bus4.clint_wlast = 0;
    bus4.clint_bready = 0; bus4.clint_rready = 0;
    bus4.clint_arvalid = 0; bus4.clint_araddr = 0; bus4.clint_arid = 0; bus4.clint_arlen = 0;
    bus4.clint_arsize = 3'b010; bus4.clint_arburst = 2'b01;

    repeat (3) step();

    // Reset state
    chk("rst_arready", {63'b0, bus1.clint_arready}, 64'd1);
    chk("rst_awready", {63'b0, bus1.clint_awready}, 64'd1);
    chk("rst_wready",  {63'b0, bus1.clint_wready},  64'd0);
    chk("rst_rvalid",  {63'b0, bus1.clint_rvalid},  64'd0);
    chk("rst_bvalid",  {63'b0, bus1.clint_bvalid},  64'd0);
    chk("rst_rdata",   {32'b0, bus1.clint_rdata},   64'd0);
    chk("rst_rresp",   {62'b0, bus1.clint_rresp},   64'd0);
    chk("rst_rlast",   {63'b0, bus1.clint_rlast},   64'd0);
    chk("rst_rid",     {60'b0, bus1.clint_rid},     64'd0);
    chk("rst_bid",     {60'b0, bus1.clint_bid},     64'd0);
    chk("rst_bresp",   {62'b0, bus1.clint_bresp},   64'd0);
`ifdef CLINT_MTIMECMP_EN
    chk("rst_mtip",    {63'b0, mtip1},              64'd0);
`endif

    // Free-running count: 100 cycles after reset
    rst1 = 1'b0;
    repeat (100) step();
    ar1(BASE, 8'd0, 4'h5);
    rbeat1(d, resp, last, id);
    chk("idle_count", {63'b0, (d >= 32'd99 && d <= 32'd101)}, 64'd1);
    chk("idle_rresp", {62'b0, resp}, 64'd0);
    chk("idle_rlast", {63'b0, last}, 64'd1);
    chk("idle_rid",   {60'b0, id},   64'h5);

    // Preload low=FFFF_FFFF, let it carry, then 2-beat read sees 1_0000_0000
    aw1(BASE, 4'h3, 8'd0);
    w1(32'hFFFF_FFFF, 4'hF, 1'b1);
    step();
    ar1(BASE, 8'd1, 4'h6);
    for (int i = 0; i < 5; i++) begin
      chk("hold_rvalid", {63'b0, bus1.clint_rvalid}, 64'd1);
      chk("hold_rdata",  {32'b0, bus1.clint_rdata},  64'h0);
      step();
    end
    rbeat1(d, resp, last, id);
    chk("carry_lo",      {32'b0, d},    64'h0);
    chk("carry_lo_last", {63'b0, last}, 64'd0);
    rbeat1(d, resp, last, id);
    chk("carry_hi",      {32'b0, d},    64'h1);
    chk("carry_hi_last", {63'b0, last}, 64'd1);
    chk("carry_rid",     {60'b0, id},   64'h6);
    b1(resp, id);
    chk("preload_bresp", {62'b0, resp}, 64'd0);
    chk("preload_bid",   {60'b0, id},   64'h3);

    // Partial-strobe write of the high word: 0x1 -> 0x5678
    aw1(BASE + 32'h4, 4'h9, 8'd0);
    w1(32'h1234_5678, 4'b0011, 1'b1);
    b1(resp, id);
    chk("strb_bresp", {62'b0, resp}, 64'd0);
    chk("strb_bid",   {60'b0, id},   64'h9);
    ar1(BASE + 32'h4, 8'd0, 4'h1);
    rbeat1(d, resp, last, id);
    chk("strb_rdata", {32'b0, d}, 64'h5678);

    // Unmapped read
    ar1(BASE + 32'h10, 8'd0, 4'h2);
    rbeat1(d, resp, last, id);
    chk("unmap_rresp", {62'b0, resp}, 64'd3);
    chk("unmap_rdata", {32'b0, d},    64'h0);
    chk("unmap_rlast", {63'b0, last}, 64'd1);
`ifndef CLINT_MTIMECMP_EN
    ar1(BASE + 32'h8, 8'd0, 4'h2);
    rbeat1(d, resp, last, id);
    chk("nocmp_rresp", {62'b0, resp}, 64'd3);
    chk("nocmp_rdata", {32'b0, d},    64'h0);
`endif

    // 2-beat write from +0x4: first beat lands, second hits +0x8
`ifdef CLINT_MTIMECMP_EN
    exp_bresp = 2'b00;
`else
    exp_bresp = 2'b11;
`endif
    aw1(BASE + 32'h4, 4'hA, 8'd1);
    w1(32'h0, 4'hF, 1'b0);
    w1(32'hDEAD, 4'b0000, 1'b1);
    b1(resp, id);
    chk("burst_bresp", {62'b0, resp}, {62'b0, exp_bresp});
    chk("burst_bid",   {60'b0, id},   64'hA);
    chk("burst_single_b", {63'b0, bus1.clint_bvalid}, 64'd0);
    ar1(BASE + 32'h4, 8'd0, 4'h1);
    rbeat1(d, resp, last, id);
    chk("burst_landed", {32'b0, d}, 64'h0);

    // TICK_DIV=4: 40 cycles -> mtime=10, then reset mid-burst
    rst4 = 1'b0;
    repeat (40) step();
    bus4.clint_araddr = BASE; bus4.clint_arlen = 8'd0; bus4.clint_arid = 4'h7;
    bus4.clint_arvalid = 1'b1;
    step();
    bus4.clint_arvalid = 1'b0;
    chk("div4_rvalid", {63'b0, bus4.clint_rvalid}, 64'd1);
    chk("div4_rdata",  {32'b0, bus4.clint_rdata},  64'd10);
    chk("div4_rid",    {60'b0, bus4.clint_rid},    64'h7);
    rst4 = 1'b1;
    step();
    chk("midrst_rvalid",  {63'b0, bus4.clint_rvalid},  64'd0);
    chk("midrst_arready", {63'b0, bus4.clint_arready}, 64'd1);
    rst4 = 1'b0;
    bus4.clint_arvalid = 1'b1;
    step();
    bus4.clint_arvalid = 1'b0;
    chk("midrst_mtime", {32'b0, bus4.clint_rdata}, 64'd0);
    bus4.clint_rready = 1'b1;
    step();
    bus4.clint_rready = 1'b0;

`ifdef CLINT_MTIMECMP_EN
    // mtimecmp = 50: mtip rises one cycle after mtime hits 50
    aw1(BASE, 4'h1, 8'd1);
    w1(32'h0, 4'hF, 1'b0);
    w1(32'h0, 4'hF, 1'b1);
    b1(resp, id);
    aw1(BASE + 32'h8, 4'h2, 8'd1);
    w1(32'd50, 4'hF, 1'b0);
    w1(32'h0, 4'hF, 1'b1);
    b1(resp, id);
    chk("cmp_bresp", {62'b0, resp}, 64'd0);
    chk("mtip_low",  {63'b0, mtip1}, 64'd0);
    begin
      int n;
      n = 0;
      while (!mtip1 && n < 200) begin step(); n++; end
    end
    chk("mtip_rise", {63'b0, mtip1}, 64'd1);
    ar1(BASE, 8'd0, 4'h3);
    rbeat1(d, resp, last, id);
    chk("mtip_time", {32'b0, d}, 64'd51);
    aw1(BASE + 32'h8, 4'h2, 8'd1);
    w1(32'hFFFF_FFFF, 4'hF, 1'b0);
    w1(32'hFFFF_FFFF, 4'hF, 1'b1);
    b1(resp, id);
    step();
    chk("mtip_fall", {63'b0, mtip1}, 64'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ysyx_23060221_clint.md
Name: ysyx_23060221_clint

Overview:
- AXI4 slave core-local interruptor (CLINT) timer, directly downstream of the bus arbiter's clint_* port group.
- Holds a free-running 64-bit mtime counter, readable and writable over AXI4 at a base address.
- Read bursts return a coherent 64-bit snapshot, so a low/high pair never tears across a carry.

Parameters:
- BASE, 32'h02000000, byte address of mtime low word (NPC builds use 32'ha0000048).
- TICK_DIV, 1, clk cycles per mtime increment, legal range 1..65535.

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  synchronous active-high reset.
- clint_awready  out  1  AW ready.
- clint_awvalid  in  1  AW valid.
- clint_awaddr  in  32  AW address.
- clint_awid  in  4  AW id.
- clint_awlen  in  8  AW burst length-1.
- clint_awsize  in  3  AW size, must be 3'b010.
- clint_awburst  in  2  AW burst type, INCR assumed.
- clint_wready  out  1  W ready.
- clint_wvalid  in  1  W valid.
- clint_wdata  in  32  W data.
- clint_wstrb  in  4  W byte strobes.
- clint_wlast  in  1  W last beat.
- clint_bready  in  1  B ready.
- clint_bvalid  out  1  B valid.
- clint_bresp  out  2  B response.
- clint_bid  out  4  B id, echoes the captured awid.
- clint_arready  out  1  AR ready.
- clint_arvalid  in  1  AR valid.
- clint_araddr  in  32  AR address.
- clint_arid  in  4  AR id.
- clint_arlen  in  8  AR burst length-1.
- clint_arsize  in  3  AR size, must be 3'b010.
- clint_arburst  in  2  AR burst type, INCR assumed.
- clint_rready  in  1  R ready.
- clint_rvalid  out  1  R valid.
- clint_rresp  out  2  R response.
- clint_rdata  out  32  R data.
- clint_rlast  out  1  R last beat.
- clint_rid  out  4  R id, echoes the captured arid.
- mtip  out  1  timer interrupt pending; present only with CLINT_MTIMECMP_EN.

Behaviour:
- Reset values:
  - mtime=0, prescaler=0.
  - Read FSM in R_IDLE, write FSM in W_IDLE.
  - Outputs: arready=1, awready=1, wready=0, rvalid=0, bvalid=0, rdata=0, rresp=0, rlast=0, rid=0, bid=0, bresp=0.
- Reset mid-burst abandons the transaction: no further R or B beats.
- Prescaler:
  - Counts 0..TICK_DIV-1.
  - mtime increments by 1 in the cycle the prescaler wraps.
  - mtime wraps 2^64-1 -> 0 silently.
- Address map, word offsets from BASE:
  - +0x0 = mtime[31:0].
  - +0x4 = mtime[63:32].
  - Any other address is unmapped.
- Read FSM:
  - R_IDLE (arready=1): on arvalid, capture arid, araddr, arlen, beat=0, snap=mtime (pre-increment value of that cycle). Go to R_DATA.
  - R_DATA (arready=0, rvalid=1): rdata=snap word at the current address. rresp=2'b00 if mapped, else 2'b11 (DECERR) with rdata=0. rlast=(beat==len).
  - On rready in R_DATA: if rlast, return to R_IDLE; else addr+=4, beat+=1.
  - First rvalid appears the cycle after the AR handshake. rvalid, rdata and rlast hold stable while rready=0.
- Write FSM:
  - W_IDLE (awready=1, wready=0): on awvalid, capture awid, awaddr. Go to W_DATA.
  - W_DATA (wready=1): each accepted beat writes the mapped word byte-wise per wstrb, then addr+=4. Any unmapped beat sets a sticky err flag. On a wlast beat, go to W_RESP.
  - W_RESP (bvalid=1): bresp = err ? 2'b11 : 2'b00. On bready, clear err and return to W_IDLE.
- W data is never accepted before AW; W beats offered early simply wait.
- Simultaneous events:
  - An AXI write to mtime in the same cycle as a tick: the written bytes win; unwritten bytes take the incremented value.
  - A read snapshot in the same cycle as a write captures the pre-write value.
  - Read and write FSMs run independently and concurrently.
- awsize/arsize other than 3'b010 is unsupported; behaviour is unspecified and asserted against in simulation.

Optional Feature:
- Macro CLINT_MTIMECMP_EN.
- Defined:
  - Adds 64-bit mtimecmp at +0x8 (low) and +0xC (high), reset value 64'hFFFF_FFFF_FFFF_FFFF.
  - mtimecmp is readable and writable with the same rules as mtime.
  - mtip is registered: mtip <= (mtime >= mtimecmp), one cycle after the compare; reset value 0.
- Undefined:
  - mtip port is absent; +0x8 and +0xC are unmapped and return DECERR.

Test Plan:
- TICK_DIV=1: release rst, idle 100 cycles, single read of BASE -> rdata=100±1, rresp=0, rlast=1, rid=arid.
- Preload mtime=0x0000_0000_FFFF_FFFF via write, then arlen=1 read at BASE -> beats 0x0000_0000 and 0x0000_0001 (coherent snapshot, no tearing); also hold rready=0 for 5 cycles and check rdata holds.
- Write BASE+4 with wdata=0x1234_5678, wstrb=4'b0011 -> bresp=0, bid=awid; read back high word -> 0x0000_5678.
- Read BASE+0x10, then a 2-beat write starting at BASE+0x4 -> read gives rresp=2'b11, rdata=0; write gives a single bresp=2'b11, and the BASE+0x4 beat still lands.
- TICK_DIV=4: 40 cycles after reset -> mtime=10; assert rst during R_DATA -> rvalid=0 the next cycle, arready=1, mtime=0.
- With CLINT_MTIMECMP_EN: write mtimecmp=50 -> mtip rises 1 cycle after mtime reaches 50; write mtimecmp=0xFFFF_FFFF_FFFF_FFFF -> mtip falls.
